dmemory: RTL and testbench

- Parametrised unified byte-addressed memory for the five-stage core; successor to the fixed-size instruction memory.
- Serves instruction fetch or load/store traffic through a valid/ready request and response handshake.
- Supports byte, half and word accesses, with sign/zero extension on reads.
- Misaligned accesses that cross a word boundary are either split into two beats or faulted, selected by parameter.
- Storage is word-organised with byte enables so it infers as SRAM.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/dmem_bank.sv | 24 ++
 rtl/dmemory.sv | 156 +++++++++++++++
 tb/tb_dmemory.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the unified data/instruction memory.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_R = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // Byte enables across two adjacent words: [3:0] first word, [7:4] second word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << offset;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic is_unsigned,
                                                input logic [31:0] data);
        case (size)
            SIZE_B:  return {{24{~is_unsigned & data[7]}}, data[7:0]};
            SIZE_H:  return {{16{~is_unsigned & data[15]}}, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage with per-byte write enables.
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 262144,
    parameter string       INIT_FILE   = "",
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clock,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmemory.sv
// Byte-addressed memory front end: handshake, range/alignment checks and
// two-beat handling of word-crossing accesses.
module dmemory
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DEPTH_WORDS    = 262144,
    parameter string       INIT_FILE      = "",
    parameter bit          MISALIGN_FAULT = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);

    state_t           state;
    logic [IDX_W-1:0] held_idx;
    logic [1:0]       held_size;
    logic [1:0]       held_off;
    logic             held_unsigned;
    logic             held_write;
    logic [31:0]      held_low;
    logic [31:0]      held_hi_wdata;
    logic [3:0]       held_hi_be;

    logic                  accept;
    logic [1:0]            off;
    logic [1:0]            last_off;
    logic [7:0]            mask;
    logic                  crossing;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  req_err;
    logic [63:0]           wr_wide;
    logic [IDX_W-1:0]      bank_addr;
    logic [3:0]            bank_be;
    logic [31:0]           bank_wdata;
    logic [31:0]           bank_rdata;
    logic [1:0]            cur_off;
    logic [31:0]           rd_lo;
    logic [31:0]           rd_word;

    assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign mask      = lane_mask(req_size, off);
    assign crossing  = |mask[7:4];

    always_comb begin
        last_off = 2'd3;
        case (req_size)
            SIZE_B:  last_off = 2'd0;
            SIZE_H:  last_off = 2'd1;
            default: last_off = 2'd3;
        endcase
    end

    // One extra bit so an address that wraps past the top is still out of range.
    assign end_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(last_off);
    assign req_err  = (req_size == SIZE_R) || (end_addr >= MEM_BYTES) || (MISALIGN_FAULT && crossing);
    assign wr_wide  = 64'(req_wdata) << {off, 3'b000};

    always_comb begin
        bank_addr  = req_addr[IDX_W+1:2];
        bank_be    = 4'b0000;
        bank_wdata = wr_wide[31:0];
        if (state == SECOND) begin
            bank_addr  = held_idx + IDX_W'(1);
            bank_be    = held_write ? held_hi_be : 4'b0000;
            bank_wdata = held_hi_wdata;
        end else if (accept && req_write && !req_err) begin
            bank_be = mask[3:0];
        end
    end

    // Second beat joins the captured low word with the next word before shifting.
    assign cur_off = (state == SECOND) ? held_off : off;
    assign rd_lo   = (state == SECOND) ? held_low : bank_rdata;
    assign rd_word = 32'({bank_rdata, rd_lo} >> {cur_off, 3'b000});

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clock(clock),
        .addr (bank_addr),
        .be   (bank_be),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
            held_idx      <= '0;
            held_size     <= '0;
            held_off      <= '0;
            held_unsigned <= 1'b0;
            held_write    <= 1'b0;
            held_low      <= '0;
            held_hi_wdata <= '0;
            held_hi_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
                    if (accept) begin
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (crossing) begin
                            state         <= SECOND;
                            held_idx      <= req_addr[IDX_W+1:2];
                            held_size     <= req_size;
                            held_off      <= off;
                            held_unsigned <= req_unsigned;
                            held_write    <= req_write;
                            held_low      <= bank_rdata;
                            held_hi_wdata <= wr_wide[63:32];
                            held_hi_be    <= mask[7:4];
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_rdata <= req_write ? 32'd0 : load_extend(req_size, req_unsigned, rd_word);
                        end
                    end
                end
                SECOND: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b0;
                    rsp_rdata <= held_write ? 32'd0 : load_extend(held_size, held_unsigned, rd_word);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmemory.sv
// Bench for dmemory: split-mode and fault-mode instances against a byte-array model.
module tb_dmemory;

    localparam int unsigned DEPTH = 64;
    localparam longint      MEM_BYTES = 4 * DEPTH;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_error    [2];

    logic [7:0] mref [2][256];
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmemory #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .INIT_FILE(""), .MISALIGN_FAULT(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

    dmemory #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .INIT_FILE(""), .MISALIGN_FAULT(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

    typedef struct {
        int          d;
        bit          w;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int d, bit w, logic [1:0] sz, bit uns, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] exp_rd, bit exp_err, int exp_lat);
        vec_t v;
        v.d = d; v.w = w; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-level model: every access is a loop over nbytes consecutive addresses.
    task automatic ref_model(input int d, input bit w, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output bit er, output int lat);
        int n, off;
        longint ai;
        n   = 1 << sz;
        ai  = longint'(a);
        off = int'(a[1:0]);
        er  = (sz == 2'd3) || (ai + n - 1 >= MEM_BYTES) || (d == 1 && off + n > 4);
        rd  = 32'd0;
        lat = 1;
        if (!er) begin
            if (off + n > 4) lat = 2;
            for (int k = 0; k < n; k++) begin
                if (w) mref[d][int'(ai) + k] = wd[8*k +: 8];
                else   rd[8*k +: 8] = mref[d][int'(ai) + k];
            end
            if (!w && !uns && n < 4 && rd[8*n-1]) begin
                for (int k = n; k < 4; k++) rd[8*k +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic do_req(input int d, input bit w, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat, output bit rdy_mid);
        int guard;
        @(negedge clock);
        req_valid[d] = 1'b1; req_write[d] = w; req_size[d] = sz;
        req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd; rsp_ready[d] = 1'b1;
        guard = 0;
        while (!req_ready[d] && guard < 16) begin
            @(negedge clock);
            guard++;
        end
        rd = 32'd0; er = 1'b0; lat = -1; rdy_mid = 1'b0;
        if (guard == 16) begin
            checks++; failures++;
            $display("FAIL accept_timeout: dut%0d addr %h never accepted", d, a);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clock); #1;
        req_valid[d] = 1'b0;
        rdy_mid = req_ready[d];
        lat = 1;
        while (!rsp_valid[d] && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        rd = rsp_rdata[d];
        er = rsp_error[d];
    endtask

    initial begin
        logic [31:0] rd, erd, exp1, exp2;
        bit er, eer, mid;
        int lat, elat;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
        end
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset_rsp_error%0d", d), 32'(rsp_error[d]), 32'd0);
            check($sformatf("reset_rsp_rdata%0d", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
        end
        reset = 1'b0;

        // Fill every word so the model holds known contents.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                logic [31:0] v;
                v = $urandom;
                ref_model(d, 1'b1, 2'd2, 1'b0, 32'(4*i), v, erd, eer, elat);
                do_req(d, 1'b1, 2'd2, 1'b0, 32'(4*i), v, rd, er, lat, mid);
                check($sformatf("fill_err d%0d w%0d", d, i), 32'(er), 32'd0);
            end
        end

        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h0,        32'h8899AABB, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'h0,        32'h0,        32'h8899AABB, 0, 1));
        vecs.push_back(mk(0, 0, 2'd0, 0, 32'h1,        32'h0,        32'hFFFFFFAA, 0, 1));
        vecs.push_back(mk(0, 0, 2'd0, 1, 32'h1,        32'h0,        32'h000000AA, 0, 1));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h4,        32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 1, 2'd1, 0, 32'h6,        32'hDEADBEEF, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'h4,        32'h0,        32'hBEEF0000, 0, 1));
        vecs.push_back(mk(0, 0, 2'd1, 0, 32'h6,        32'h0,        32'hFFFFBEEF, 0, 1));
        vecs.push_back(mk(0, 1, 2'd2, 0, 32'h7,        32'h11223344, 32'h0,        0, 2));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'h7,        32'h0,        32'h11223344, 0, 2));
        vecs.push_back(mk(0, 0, 2'd0, 1, 32'h7,        32'h0,        32'h00000044, 0, 1));
        vecs.push_back(mk(0, 0, 2'd0, 1, 32'hA,        32'h0,        32'h00000011, 0, 1));
        vecs.push_back(mk(0, 0, 2'd1, 0, 32'h9,        32'h0,        32'h00001122, 0, 1));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'hFE,       32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 2'd3, 0, 32'h10,       32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 2'd1, 0, 32'hFF,       32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 2'd0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 0, 2'd2, 0, 32'hFFFFFFFE, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 1, 2'd2, 0, 32'h0,        32'hCAFEF00D, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h2,        32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 1, 2'd2, 0, 32'h2,        32'h12345678, 32'h0,        1, 1));
        vecs.push_back(mk(1, 0, 2'd2, 0, 32'h0,        32'h0,        32'hCAFEF00D, 0, 1));
        vecs.push_back(mk(1, 0, 2'd1, 0, 32'h3,        32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(1, 0, 2'd0, 0, 32'h3,        32'h0,        32'hFFFFFFCA, 0, 1));

        foreach (vecs[i]) begin
            ref_model(vecs[i].d, vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, erd, eer, elat);
            do_req(vecs[i].d, vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, rd, er, lat, mid);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_ready_after_accept", i), 32'(mid), 32'(vecs[i].exp_lat == 1));
        end

        // Backpressure: response must hold while rsp_ready is low and the next request waits.
        @(negedge clock); @(negedge clock);
        ref_model(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, exp1, eer, elat);
        ref_model(0, 1'b0, 2'd0, 1'b1, 32'h1, 32'h0, exp2, eer, elat);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h0;
        @(posedge clock); #1;
        req_size[0] = 2'd0; req_unsigned[0] = 1'b1; req_addr[0] = 32'h1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_valid_c%0d", c), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("bp_rdata_c%0d", c), rsp_rdata[0], exp1);
            check($sformatf("bp_req_ready_c%0d", c), 32'(req_ready[0]), 32'd0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        rsp_ready[0] = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        check("bp_next_valid", 32'(rsp_valid[0]), 32'd1);
        check("bp_next_rdata", rsp_rdata[0], exp2);

        // Reset in SECOND: response dropped, first-beat bytes stay written.
        @(negedge clock); @(negedge clock);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h21; req_wdata[0] = 32'hA1B2C3D4;
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        check("second_req_ready", 32'(req_ready[0]), 32'd0);
        reset = 1'b1;
        #1;
        check("second_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("second_reset_req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        mref[0][8'h21] = 8'hD4; mref[0][8'h22] = 8'hC3; mref[0][8'h23] = 8'hB2;
        ref_model(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, erd, eer, elat);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, mid);
        check("second_partial_word0", rd, erd);
        ref_model(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, erd, eer, elat);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lat, mid);
        check("second_partial_word1", rd, erd);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            int d, s;
            logic [1:0] sz;
            logic [31:0] a, wd;
            bit w, uns;
            d   = i % 2;
            s   = $urandom_range(0, 15);
            sz  = (s == 15) ? 2'd3 : 2'(s % 3);
            a   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 259));
            w   = 1'($urandom);
            uns = 1'($urandom);
            wd  = $urandom;
            ref_model(d, w, sz, uns, a, wd, erd, eer, elat);
            do_req(d, w, sz, uns, a, wd, rd, er, lat, mid);
            check($sformatf("rnd%0d_rdata d%0d a%h", i, d, a), rd, erd);
            check($sformatf("rnd%0d_error", i), 32'(er), 32'(eer));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_ready", i), 32'(mid), 32'(elat == 1));
        end

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
